// File: rtl/dll_rx_dllp_parser.sv
// Receive-side DLLP parser: Ack/Nak filtering, partner credit limits and FC init state machine.
// Optional CRC-16 check of each DLLP is enabled by defining DLLP_CRC_CHECK_EN.
module dll_rx_dllp_parser #(
   parameter int CREDIT_DEPTH  = 12,
   parameter int SEQ_WIDTH     = 12,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     sclk,
   input  logic                     srst,
   input  logic [47:0]              dllp_data_i,
   input  logic                     dllp_valid_i,
   output logic                     dllp_ready_o,
   output logic [SEQ_WIDTH-1:0]     acknak_seq_num_o,
   output logic                     acknak_seq_en_o,
   output logic                     acknak_is_nak_o,
   output logic [CREDIT_DEPTH-1:0]  ep_cl_p_h_o,
   output logic [CREDIT_DEPTH-1:0]  ep_cl_p_d_o,
   output logic [CREDIT_DEPTH-1:0]  ep_cl_np_h_o,
   output logic [CREDIT_DEPTH-1:0]  ep_cl_cpl_h_o,
   output logic [CREDIT_DEPTH-1:0]  ep_cl_cpl_d_o,
   output logic [1:0]               fc_state_o,
   output logic                     dl_up_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

   localparam logic [1:0] ST_INACTIVE = 2'd0;
   localparam logic [1:0] ST_INIT1    = 2'd1;
   localparam logic [1:0] ST_INIT2    = 2'd2;
   localparam logic [1:0] ST_ACTIVE   = 2'd3;

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + ERR_CNT_WIDTH'(1);
   endfunction

`ifdef DLLP_CRC_CHECK_EN
   function automatic logic [15:0] crc16_calc(input logic [31:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
      return ~c;
   endfunction
`endif

   logic                    rdy;
   logic [47:0]             data_p0;
   logic                    vld_p0;
   logic                    crc_ok_p0;
   logic [31:0]             data_p1;
   logic                    vld_p1;
   logic                    crc_ok_p1;

   logic [1:0]              state;
   logic [1:0]              state_nxt;
   logic [2:0]              rec;
   logic [2:0]              new_rec;
   logic [SEQ_WIDTH-1:0]    last_ack;

   logic [7:0]              byte0;
   logic [7:0]              hdr_fc;
   logic [11:0]             dat_fc;
   logic [CREDIT_DEPTH-1:0] hdr_ext;
   logic [CREDIT_DEPTH-1:0] dat_ext;
   logic [SEQ_WIDTH-1:0]    seq_in;
   logic [SEQ_WIDTH-1:0]    ack_d;
   logic [1:0]              fc_sel;
   logic                    good;
   logic                    crc_bad;
   logic                    fc_ok;
   logic                    is_init1;
   logic                    is_init2;
   logic                    is_upd;
   logic                    is_ack;
   logic                    is_nak;
   logic                    ack_fwd;
   logic                    nak_fwd;
   logic                    load_lim;
   logic                    decode_unused;

   assign dllp_ready_o = rdy;

   // Input capture: no backpressure, ready rises on the first edge out of reset
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         rdy    <= 1'b0;
         vld_p0 <= 1'b0;
      end else begin
         rdy    <= 1'b1;
         vld_p0 <= dllp_valid_i & rdy;
      end
   end

   always_ff @(posedge sclk) begin
      data_p0 <= dllp_data_i;
   end

`ifdef DLLP_CRC_CHECK_EN
   assign crc_ok_p0 = (crc16_calc(data_p0[31:0]) == {data_p0[39:32], data_p0[47:40]});
`else
   logic crc_bytes_unused;
   assign crc_ok_p0        = 1'b1;
   assign crc_bytes_unused = ^data_p0[47:32];
`endif

   // S1: beat plus CRC verdict
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) vld_p1 <= 1'b0;
      else      vld_p1 <= vld_p0;
   end

   always_ff @(posedge sclk) begin
      data_p1   <= data_p0[31:0];
      crc_ok_p1 <= crc_ok_p0;
   end

   // S2 decode
   always_comb begin
      byte0    = data_p1[7:0];
      hdr_fc   = {data_p1[13:8], data_p1[23:22]};
      dat_fc   = {data_p1[19:16], data_p1[31:24]};
      hdr_ext  = CREDIT_DEPTH'(hdr_fc);
      dat_ext  = CREDIT_DEPTH'(dat_fc);
      seq_in   = SEQ_WIDTH'(dat_fc);
      ack_d    = seq_in - last_ack;
      good     = vld_p1 & crc_ok_p1;
      crc_bad  = vld_p1 & ~crc_ok_p1;
      fc_sel   = byte0[5:4];
      fc_ok    = good && (byte0[3:0] == 4'h0) && (byte0[5:4] != 2'b11);
      is_init1 = fc_ok && (byte0[7:6] == 2'b01);
      is_init2 = fc_ok && (byte0[7:6] == 2'b11);
      is_upd   = fc_ok && (byte0[7:6] == 2'b10);
      is_ack   = good && (byte0 == 8'h00);
      is_nak   = good && (byte0 == 8'h10);
      // Forward an Ack only when it advances last_ack by 1..half the sequence space
      ack_fwd  = is_ack && (state == ST_ACTIVE) && (ack_d != '0) && !ack_d[SEQ_WIDTH-1];
      nak_fwd  = is_nak && (state == ST_ACTIVE);
      load_lim = (is_init1 && (state == ST_INIT1)) || (is_upd && (state == ST_ACTIVE));
   end

   assign decode_unused = ^{data_p1[15:14], data_p1[21:20]};

   always_comb begin
      new_rec = 3'b000;
      if (is_init1 && (state == ST_INIT1)) begin
         case (fc_sel)
            2'b00:   new_rec = 3'b001;
            2'b01:   new_rec = 3'b010;
            default: new_rec = 3'b100;
         endcase
      end
   end

   // FC init state machine
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) state <= ST_INACTIVE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INACTIVE: state_nxt = ST_INIT1;
         ST_INIT1:    if ((rec | new_rec) == 3'b111) state_nxt = ST_INIT2;
         ST_INIT2:    if (is_init2 || is_upd) state_nxt = ST_ACTIVE;
         default:     state_nxt = ST_ACTIVE;
      endcase
   end

   always_comb begin
      fc_state_o = state;
      dl_up_o    = (state == ST_ACTIVE);
   end

   // S2 output registers
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         acknak_seq_num_o <= '0;
         acknak_seq_en_o  <= 1'b0;
         acknak_is_nak_o  <= 1'b0;
         last_ack         <= '1;
         rec              <= 3'b000;
         ep_cl_p_h_o      <= '0;
         ep_cl_p_d_o      <= '0;
         ep_cl_np_h_o     <= '0;
         ep_cl_cpl_h_o    <= '0;
         ep_cl_cpl_d_o    <= '0;
         err_cnt_o        <= '0;
      end else begin
         acknak_seq_en_o <= ack_fwd | nak_fwd;
         if (ack_fwd || nak_fwd) begin
            acknak_seq_num_o <= seq_in;
            acknak_is_nak_o  <= nak_fwd;
            last_ack         <= seq_in;
         end
         rec <= rec | new_rec;
         if (load_lim) begin
            case (fc_sel)
               2'b00: begin
                  ep_cl_p_h_o <= hdr_ext;
                  ep_cl_p_d_o <= dat_ext;
               end
               2'b01:   ep_cl_np_h_o <= hdr_ext;
               default: begin
                  ep_cl_cpl_h_o <= hdr_ext;
                  ep_cl_cpl_d_o <= dat_ext;
               end
            endcase
         end
         if (crc_bad) err_cnt_o <= sat_inc(err_cnt_o);
      end
   end

endmodule
